// File: rtl/serial_to_parallel_framed.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_framed
// Purpose  : Framed serial-to-parallel deserializer. It has a held output word
//            with a valid/ready handshake, a sticky overrun flag and a
//            daisy-chain serial output.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel_framed #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bitValid,
    input  logic             dataIn,
    input  logic             frameStart,
    input  logic             outputEnable,
    input  logic             wordReady,
    output logic             dataOut,
    output logic [WIDTH-1:0] outputs,
    output logic             wordValid,
    output logic             overrun
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_sh;
    logic               r_ch;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hold;
    logic               r_word_valid;
    logic               r_overrun;

    logic [WIDTH-1:0]   w_shifted;
    logic               w_chain;
    logic               w_complete;
    logic               w_consume;

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $error("serial_to_parallel_framed: WIDTH must be in 2..32");
    end

    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {r_sh[WIDTH-2:0], dataIn};
        assign w_chain   = r_sh[WIDTH-1];
    end else begin : g_lsb_first
        assign w_shifted = {dataIn, r_sh[WIDTH-1:1]};
        assign w_chain   = r_sh[0];
    end

    // A frameStart bit always opens a new word, so it can never complete one.
    assign w_complete = bitValid && !frameStart && (r_cnt == c_last);
    assign w_consume  = r_word_valid && wordReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sh         <= '0;
            r_ch         <= 1'b0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (bitValid) begin
                r_sh <= w_shifted;
                r_ch <= w_chain;
                if (frameStart) begin
                    r_cnt <= c_one;
                end else if (r_cnt == c_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end

            // A word completing while the held one is being taken replaces it
            // in place, so wordValid stays high across back-to-back words.
            if (w_complete) begin
                if (!r_word_valid || wordReady) begin
                    r_hold       <= w_shifted;
                    r_word_valid <= 1'b1;
                end else begin
                    r_overrun    <= 1'b1;
                end
            end else if (w_consume) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign dataOut   = r_ch;
    assign wordValid = r_word_valid;
    assign overrun   = r_overrun;
    assign outputs   = outputEnable ? r_hold : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel_framed.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel_framed
// Purpose  : Self-checking bench for serial_to_parallel_framed. It runs an
//            MSB-first and an LSB-first instance from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel_framed;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bitValid = 1'b0;
    logic       dataIn = 1'b0;
    logic       frameStart = 1'b0;
    logic       outputEnable = 1'b1;
    logic       wordReady = 1'b0;
    wire        dout_msb, dout_lsb;
    wire  [7:0] out_msb, out_lsb;
    wire        wv_msb, wv_lsb, ovr_msb, ovr_lsb;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current frame, all accepted bits since
    // reset, and the expected held words.
    logic fb[$];
    logic hist[$];
    logic [7:0] q_msb[$];
    logic [7:0] q_lsb[$];
    logic m_valid = 1'b0;
    logic m_ovr   = 1'b0;

    always #5 clk = ~clk;

    serial_to_parallel_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clk), .reset(reset), .bitValid(bitValid), .dataIn(dataIn),
        .frameStart(frameStart), .outputEnable(outputEnable), .wordReady(wordReady),
        .dataOut(dout_msb), .outputs(out_msb), .wordValid(wv_msb), .overrun(ovr_msb)
    );

    serial_to_parallel_framed #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock(clk), .reset(reset), .bitValid(bitValid), .dataIn(dataIn),
        .frameStart(frameStart), .outputEnable(outputEnable), .wordReady(wordReady),
        .dataOut(dout_lsb), .outputs(out_lsb), .wordValid(wv_lsb), .overrun(ovr_lsb)
    );

    // One clock of stimulus. The model is updated from the values in force
    // before the edge. Outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic bv, input logic din, input logic fs);
        logic [7:0] wm, wl;
        bitValid   = bv;
        dataIn     = din;
        frameStart = fs;
        if (bv) begin
            if (!fs && fb.size() == 7) begin
                fb.push_back(din);
                for (int i = 0; i < 8; i++) begin
                    wm[7-i] = fb[i];
                    wl[i]   = fb[i];
                end
                fb.delete();
                if (!m_valid || wordReady) begin
                    q_msb.push_back(wm);
                    q_lsb.push_back(wl);
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                if (fs) fb.delete();
                fb.push_back(din);
                if (m_valid && wordReady) m_valid = 1'b0;
            end
            hist.push_back(din);
        end else if (m_valid && wordReady) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        bitValid   = 1'b0;
        frameStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tick(1'b1, v[i], 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fb.delete(); hist.delete(); q_msb.delete(); q_lsb.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic test_reset();
        outputEnable = 1'b1;
        do_reset();
        checks++; if (wv_msb !== 1'b0 || wv_lsb !== 1'b0) begin errors++;
            $display("FAIL reset_wordValid got %b/%b want 0", wv_msb, wv_lsb); end
        checks++; if (ovr_msb !== 1'b0 || ovr_lsb !== 1'b0) begin errors++;
            $display("FAIL reset_overrun got %b/%b want 0", ovr_msb, ovr_lsb); end
        checks++; if (dout_msb !== 1'b0 || dout_lsb !== 1'b0) begin errors++;
            $display("FAIL reset_dataOut got %b/%b want 0", dout_msb, dout_lsb); end
        checks++; if (out_msb !== 8'h00 || out_lsb !== 8'h00) begin errors++;
            $display("FAIL reset_outputs got %h/%h want 00", out_msb, out_lsb); end
    endtask

    task automatic test_basic();
        logic [7:0] em, el;
        wordReady = 1'b1;
        send_byte(8'hA5);
        em = q_msb.pop_front(); el = q_lsb.pop_front();
        checks++; if (wv_msb !== 1'b1 || wv_lsb !== 1'b1) begin errors++;
            $display("FAIL basic_valid got %b/%b want 1", wv_msb, wv_lsb); end
        checks++; if (out_msb !== 8'hA5 || out_msb !== em) begin errors++;
            $display("FAIL basic_msb_A5 got %h want A5 (model %h)", out_msb, em); end
        checks++; if (out_lsb !== 8'hA5 || out_lsb !== el) begin errors++;
            $display("FAIL basic_lsb_A5 got %h want A5 (model %h)", out_lsb, el); end
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (wv_msb !== 1'b0 || wv_lsb !== 1'b0) begin errors++;
            $display("FAIL basic_consumed got %b/%b want 0", wv_msb, wv_lsb); end
        send_byte(8'h80);
        em = q_msb.pop_front(); el = q_lsb.pop_front();
        checks++; if (out_msb !== 8'h80 || out_msb !== em) begin errors++;
            $display("FAIL basic_msb_80 got %h want 80 (model %h)", out_msb, em); end
        checks++; if (out_lsb !== 8'h01 || out_lsb !== el) begin errors++;
            $display("FAIL basic_lsb_01 got %h want 01 (model %h)", out_lsb, el); end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_frame();
        logic [7:0] v;
        wordReady = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        v = 8'h96;
        tick(1'b1, v[7], 1'b1);
        for (int i = 6; i >= 0; i--) tick(1'b1, v[i], 1'b0);
        checks++; if (wv_msb !== 1'b1 || out_msb !== 8'h96 || q_msb.size() != 1) begin errors++;
            $display("FAIL frame_word got valid=%b out=%h queued=%0d want 1/96/1",
                     wv_msb, out_msb, q_msb.size()); end
        checks++; if (ovr_msb !== 1'b0 || ovr_lsb !== 1'b0) begin errors++;
            $display("FAIL frame_no_overrun got %b/%b want 0", ovr_msb, ovr_lsb); end
        void'(q_msb.pop_front()); void'(q_lsb.pop_front());
        tick(1'b0, 1'b0, 1'b0);
        // frameStart on what would have been the eighth bit restarts framing
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        checks++; if (wv_msb !== 1'b0 || m_valid !== 1'b0) begin errors++;
            $display("FAIL frame_restart_no_word got %b want 0", wv_msb); end
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0);
        checks++; if (wv_msb !== 1'b1 || out_msb !== 8'h7F || out_lsb !== 8'hFE) begin errors++;
            $display("FAIL frame_restart_word got %b %h/%h want 1 7f/fe", wv_msb, out_msb, out_lsb); end
        void'(q_msb.pop_front()); void'(q_lsb.pop_front());
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] em;
        wordReady = 1'b0;
        send_byte(8'h12);
        em = q_msb.pop_front(); void'(q_lsb.pop_front());
        checks++; if (out_msb !== em || out_msb !== 8'h12) begin errors++;
            $display("FAIL b2b_first got %h want 12", out_msb); end
        for (int i = 7; i >= 1; i--) tick(1'b1, 8'h34 >> i, 1'b0);
        wordReady = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        wordReady = 1'b0;
        em = q_msb.pop_front(); void'(q_lsb.pop_front());
        checks++; if (wv_msb !== 1'b1 || out_msb !== 8'h34 || out_msb !== em) begin errors++;
            $display("FAIL b2b_replace got valid=%b out=%h want 1/34", wv_msb, out_msb); end
        checks++; if (ovr_msb !== 1'b0) begin errors++;
            $display("FAIL b2b_no_overrun got %b want 0", ovr_msb); end
        wordReady = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        logic b, ed;
        logic [7:0] em, el;
        wordReady = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                b = 1'($urandom_range(0, 1));
                tick(1'b1, b, 1'b0);
                ed = (hist.size() > 8) ? hist[hist.size()-9] : 1'b0;
                checks++; if (dout_msb !== ed || dout_lsb !== ed) begin errors++;
                    $display("FAIL gaps_dataOut got %b/%b want %b", dout_msb, dout_lsb, ed); end
            end
            if (q_msb.size() == 0) begin
                checks++; errors++;
                $display("FAIL gaps_scoreboard got empty want 1 word");
            end else begin
                em = q_msb.pop_front(); el = q_lsb.pop_front();
                checks++; if (wv_msb !== 1'b1 || out_msb !== em || out_lsb !== el) begin errors++;
                    $display("FAIL gaps_word got %b %h/%h want 1 %h/%h",
                             wv_msb, out_msb, out_lsb, em, el); end
            end
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        wordReady = 1'b0;
        send_byte(8'h3C);
        checks++; if (out_msb !== 8'h3C || out_lsb !== 8'h3C || q_msb.pop_front() !== 8'h3C) begin errors++;
            $display("FAIL ovr_first got %h/%h want 3c", out_msb, out_lsb); end
        void'(q_lsb.pop_front());
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 1'b0);
        checks++; if (ovr_msb !== 1'b0 || m_ovr !== 1'b0) begin errors++;
            $display("FAIL ovr_early got %b want 0", ovr_msb); end
        tick(1'b1, 1'b1, 1'b0);
        checks++; if (ovr_msb !== 1'b1 || ovr_lsb !== 1'b1) begin errors++;
            $display("FAIL ovr_set got %b/%b want 1", ovr_msb, ovr_lsb); end
        checks++; if (out_msb !== 8'h3C || wv_msb !== 1'b1) begin errors++;
            $display("FAIL ovr_hold got %h valid=%b want 3c/1", out_msb, wv_msb); end
        wordReady = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (wv_msb !== 1'b0 || ovr_msb !== 1'b1 || ovr_msb !== m_ovr) begin errors++;
            $display("FAIL ovr_sticky got valid=%b ovr=%b want 0/1", wv_msb, ovr_msb); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] em;
        wordReady = 1'b0;
        send_byte(8'h11);
        void'(q_msb.pop_front()); void'(q_lsb.pop_front());
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        do_reset();
        checks++; if (wv_msb !== 1'b0 || out_msb !== 8'h00 || out_lsb !== 8'h00) begin errors++;
            $display("FAIL rstmid_state got valid=%b out=%h/%h want 0 00", wv_msb, out_msb, out_lsb); end
        checks++; if (dout_msb !== 1'b0 || ovr_msb !== 1'b0) begin errors++;
            $display("FAIL rstmid_flags got dout=%b ovr=%b want 0/0", dout_msb, ovr_msb); end
        wordReady = 1'b1;
        send_byte(8'h4B);
        em = q_msb.pop_front(); void'(q_lsb.pop_front());
        checks++; if (out_msb !== 8'h4B || out_lsb !== 8'hD2 || out_msb !== em) begin errors++;
            $display("FAIL rstmid_word got %h/%h want 4b/d2", out_msb, out_lsb); end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_output_enable();
        wordReady    = 1'b0;
        outputEnable = 1'b0;
        send_byte(8'h69);
        checks++; if (wv_msb !== 1'b1) begin errors++;
            $display("FAIL oe_valid got %b want 1", wv_msb); end
        checks++; if (out_msb === 8'h69) begin errors++;
            $display("FAIL oe_highz got %h want zz", out_msb); end
        outputEnable = 1'b1;
        #1;
        checks++; if (out_msb !== q_msb.pop_front()) begin errors++;
            $display("FAIL oe_drive got %h want 69", out_msb); end
        void'(q_lsb.pop_front());
        wordReady = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++; if (wv_msb !== 1'b0) begin errors++;
            $display("FAIL oe_consume got %b want 0", wv_msb); end
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout got no finish want finish");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_basic();
        test_frame();
        test_back_to_back();
        test_gaps();
        test_overrun();
        test_reset_mid();
        test_output_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
